// File: rtl/sdio_dat_block_source.sv
// Multi-block byte source for the SDIO DAT-line transmitter: buffers host bytes
// in a FIFO and releases them one full block at a time to the DAT stream engine.
//
//   state     | meaning
//   IDLE      | no transfer; accepts cfg_start
//   WAIT_DATA | waiting for a full block in the FIFO and an idle line
//   ARM       | issues start_write, loads the block byte counter
//   STREAM    | serves data_req from the FIFO
//   BLOCK_END | waits for the engine to finish sending the block
module sdio_dat_block_source #(
    parameter int FIFO_DEPTH = 512,
    parameter int LEN_W      = 9,
    parameter int CNT_W      = 9
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          cfg_start,
    input  logic                          cfg_abort,
    input  logic [LEN_W-1:0]              cfg_block_len,
    input  logic [CNT_W-1:0]              cfg_block_count,
    output logic                          start_write,
    input  logic                          data_req,
    output logic [7:0]                    data,
    output logic                          data_strobe,
    output logic                          data_empty,
    input  logic                          line_busy,
    output logic                          busy,
    output logic [CNT_W-1:0]              block_index,
    output logic                          done,
    output logic                          cfg_error
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_DATA = 3'd1;
    localparam logic [2:0] ARM       = 3'd2;
    localparam logic [2:0] STREAM    = 3'd3;
    localparam logic [2:0] BLOCK_END = 3'd4;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;

    logic [2:0]       state_q, state_d;
    logic [LEN_W:0]   len_q, len_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] block_index_q, block_index_d;
    logic [LEN_W:0]   bytes_left_q, bytes_left_d;
    logic             seen_busy_q, seen_busy_d;
    logic             busy_q, busy_d;
    logic             start_write_q, start_write_d;
    logic             data_empty_q, data_empty_d;
    logic             done_q, done_d;
    logic             cfg_error_q, cfg_error_d;
    logic [7:0]       data_q;
    logic             data_strobe_q;

    logic [LEN_W:0]   len_eff;
    logic             len_too_big;
    logic             level_ok;
    logic             abort;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] index_inc;

    // A zero length field encodes the full 2^LEN_W block.
    always_comb begin
        len_eff = {1'b0, cfg_block_len};
        if (cfg_block_len == '0) begin
            len_eff = {1'b1, {LEN_W{1'b0}}};
        end
    end

    assign len_too_big = 32'(len_eff) > 32'(FIFO_DEPTH);
    assign level_ok    = 32'(level_q) >= 32'(len_q);
    assign abort       = cfg_abort && (state_q != IDLE);
    assign wr_ready    = (level_q != LW'(FIFO_DEPTH));
    assign push        = wr_valid && wr_ready;
    assign pop         = (state_q == STREAM) && data_req && (bytes_left_q != '0) && !cfg_abort;
    assign index_inc   = block_index_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        count_d       = count_q;
        block_index_d = block_index_q;
        bytes_left_d  = bytes_left_q;
        seen_busy_d   = seen_busy_q;
        busy_d        = busy_q;
        data_empty_d  = data_empty_q;
        start_write_d = 1'b0;
        done_d        = 1'b0;
        cfg_error_d   = 1'b0;

        if (abort) begin
            state_d      = IDLE;
            data_empty_d = 1'b1;
            done_d       = 1'b1;
            busy_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        if ((cfg_block_count == '0) || len_too_big) begin
                            cfg_error_d = 1'b1;
                        end else begin
                            len_d         = len_eff;
                            count_d       = cfg_block_count;
                            block_index_d = '0;
                            busy_d        = 1'b1;
                            state_d       = WAIT_DATA;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (level_ok && !line_busy) begin
                        state_d = ARM;
                    end
                end
                ARM: begin
                    start_write_d = 1'b1;
                    data_empty_d  = 1'b0;
                    bytes_left_d  = len_q;
                    seen_busy_d   = 1'b0;
                    state_d       = STREAM;
                end
                STREAM: begin
                    if (line_busy) begin
                        seen_busy_d = 1'b1;
                    end
                    if (data_req) begin
                        if (bytes_left_q != '0) begin
                            bytes_left_d = bytes_left_q - (LEN_W+1)'(1);
                        end else begin
                            data_empty_d = 1'b1;
                            state_d      = BLOCK_END;
                        end
                    end
                end
                BLOCK_END: begin
                    // The engine may raise line_busy late, so a block ends only on a fall.
                    if (!seen_busy_q) begin
                        if (line_busy) begin
                            seen_busy_d = 1'b1;
                        end
                    end else if (!line_busy) begin
                        block_index_d = index_inc;
                        if (index_inc == count_q) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_DATA;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            state_q       <= IDLE;
            len_q         <= '0;
            count_q       <= '0;
            block_index_q <= '0;
            bytes_left_q  <= '0;
            seen_busy_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_write_q <= 1'b0;
            data_empty_q  <= 1'b1;
            done_q        <= 1'b0;
            cfg_error_q   <= 1'b0;
            data_q        <= 8'h00;
            data_strobe_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                data_q   <= mem[rd_ptr_q];
            end
            if (push && !pop) begin
                level_q <= level_q + LW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LW'(1);
            end
            data_strobe_q <= pop;
            state_q       <= state_d;
            len_q         <= len_d;
            count_q       <= count_d;
            block_index_q <= block_index_d;
            bytes_left_q  <= bytes_left_d;
            seen_busy_q   <= seen_busy_d;
            busy_q        <= busy_d;
            start_write_q <= start_write_d;
            data_empty_q  <= data_empty_d;
            done_q        <= done_d;
            cfg_error_q   <= cfg_error_d;
        end
    end

    assign fifo_level  = level_q;
    assign start_write = start_write_q;
    assign data        = data_q;
    assign data_strobe = data_strobe_q;
    assign data_empty  = data_empty_q;
    assign busy        = busy_q;
    assign block_index = block_index_q;
    assign done        = done_q;
    assign cfg_error   = cfg_error_q;

endmodule

// File: tb/tb_sdio_dat_block_source.sv
// Directed bench for sdio_dat_block_source; a second, shallower instance
// shares all inputs and is used only for the over-length start rejection.
module tb_sdio_dat_block_source;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       cfg_start;
    logic       cfg_abort;
    logic [8:0] cfg_block_len;
    logic [8:0] cfg_block_count;
    logic       data_req;
    logic       line_busy;

    logic       wr_ready, start_write, data_strobe, data_empty, busy, done, cfg_error;
    logic [9:0] fifo_level;
    logic [7:0] data;
    logic [8:0] block_index;

    logic       wr_ready_b, start_write_b, data_strobe_b, data_empty_b, busy_b, done_b, cfg_error_b;
    logic [8:0] fifo_level_b;
    logic [7:0] data_b;
    logic [8:0] block_index_b;

    int n_tests = 0;
    int n_fail  = 0;
    int n;

    sdio_dat_block_source #(.FIFO_DEPTH(512), .LEN_W(9), .CNT_W(9)) u_dut (
        .clock(clock), .reset_n(reset_n), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .fifo_level(fifo_level), .cfg_start(cfg_start),
        .cfg_abort(cfg_abort), .cfg_block_len(cfg_block_len),
        .cfg_block_count(cfg_block_count), .start_write(start_write),
        .data_req(data_req), .data(data), .data_strobe(data_strobe),
        .data_empty(data_empty), .line_busy(line_busy), .busy(busy),
        .block_index(block_index), .done(done), .cfg_error(cfg_error)
    );

    sdio_dat_block_source #(.FIFO_DEPTH(256), .LEN_W(9), .CNT_W(9)) u_dut_small (
        .clock(clock), .reset_n(reset_n), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready_b), .fifo_level(fifo_level_b), .cfg_start(cfg_start),
        .cfg_abort(cfg_abort), .cfg_block_len(cfg_block_len),
        .cfg_block_count(cfg_block_count), .start_write(start_write_b),
        .data_req(data_req), .data(data_b), .data_strobe(data_strobe_b),
        .data_empty(data_empty_b), .line_busy(line_busy), .busy(busy_b),
        .block_index(block_index_b), .done(done_b), .cfg_error(cfg_error_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic start_xfer(input logic [8:0] len, input logic [8:0] cnt);
        cfg_block_len   = len;
        cfg_block_count = cnt;
        cfg_start       = 1'b1;
        tick();
        cfg_start       = 1'b0;
    endtask

    task automatic wait_start(input int max, output int cycles);
        cycles = 0;
        while (start_write !== 1'b1 && cycles < max) begin
            tick();
            cycles++;
        end
        chk("start_write_seen", 32'(start_write), 1);
    endtask

    task automatic wait_done(input int max, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < max) begin
            tick();
            cycles++;
        end
        chk("done_seen", 32'(done), 1);
    endtask

    // Back-to-back requests for n bytes, then the terminating request.
    task automatic stream(input int nbytes, input logic [7:0] first);
        logic [7:0] exp_b;
        for (int i = 0; i < nbytes; i++) begin
            data_req = 1'b1;
            tick();
            if (i == 0) chk("start_write_pulse", 32'(start_write), 0);
            exp_b = first + 8'(i);
            chk("strobe", 32'(data_strobe), 1);
            chk("data", 32'(data), 32'(exp_b));
        end
        tick();
        data_req = 1'b0;
        chk("empty_after_last", 32'(data_empty), 1);
        chk("no_strobe_at_end", 32'(data_strobe), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sw_cnt;
        reset_n = 1'b0; wr_data = '0; wr_valid = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
        cfg_block_len = '0; cfg_block_count = '0; data_req = 1'b0; line_busy = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_start_write", 32'(start_write), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_strobe", 32'(data_strobe), 0);
        chk("rst_empty", 32'(data_empty), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_block_index", 32'(block_index), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cfg_error", 32'(cfg_error), 0);

        // Single 4-byte block; line_busy only rises after the block is drained.
        for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
        chk("t1_level", 32'(fifo_level), 4);
        start_xfer(9'd4, 9'd1);
        chk("t1_busy", 32'(busy), 1);
        wait_start(20, n);
        chk("t1_start_latency", n, 2);
        chk("t1_empty_armed", 32'(data_empty), 0);
        stream(4, 8'h10);
        chk("t1_level_drained", 32'(fifo_level), 0);
        repeat (3) tick();
        chk("t1_no_done_before_busy", 32'(done), 0);
        chk("t1_busy_held", 32'(busy), 1);
        line_busy = 1'b1;
        tick();
        line_busy = 1'b0;
        wait_done(20, n);
        chk("t1_done_latency", n, 1);
        chk("t1_block_index", 32'(block_index), 1);
        chk("t1_busy_clear", 32'(busy), 0);
        tick();
        chk("t1_done_pulse", 32'(done), 0);

        // Three 8-byte blocks, starting with only 5 bytes buffered.
        for (int i = 0; i < 5; i++) push_byte(8'h20 + 8'(i));
        start_xfer(9'd8, 9'd3);
        sw_cnt = 0;
        repeat (10) begin
            tick();
            if (start_write) sw_cnt++;
        end
        chk("t2_no_early_start", sw_cnt, 0);
        for (int i = 5; i < 8; i++) push_byte(8'h20 + 8'(i));
        wait_start(10, n);
        line_busy = 1'b1;
        stream(8, 8'h20);
        for (int i = 8; i < 24; i++) push_byte(8'h20 + 8'(i));
        chk("t2_no_done_mid", 32'(done), 0);
        line_busy = 1'b0;
        wait_start(20, n);
        chk("t2_block_index_1", 32'(block_index), 1);
        line_busy = 1'b1;
        stream(8, 8'h28);
        line_busy = 1'b0;
        wait_start(20, n);
        chk("t2_block_index_2", 32'(block_index), 2);
        line_busy = 1'b1;
        stream(8, 8'h30);
        line_busy = 1'b0;
        wait_done(20, n);
        chk("t2_block_index_3", 32'(block_index), 3);
        chk("t2_level", 32'(fifo_level), 0);

        // Full-depth block (length field 0) across the pointer wrap.
        for (int i = 0; i < 512; i++) push_byte(8'(i));
        chk("t3_level_full", 32'(fifo_level), 512);
        chk("t3_wr_ready_full", 32'(wr_ready), 0);
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("t3_level_no_overflow", 32'(fifo_level), 512);
        start_xfer(9'd0, 9'd1);
        chk("t3_small_cfg_error", 32'(cfg_error_b), 1);
        chk("t3_small_busy", 32'(busy_b), 0);
        chk("t3_cfg_error", 32'(cfg_error), 0);
        chk("t3_busy", 32'(busy), 1);
        wait_start(10, n);
        line_busy = 1'b1;
        stream(512, 8'h00);
        line_busy = 1'b0;
        wait_done(20, n);
        chk("t3_level_empty", 32'(fifo_level), 0);

        // Push and pop in the same cycle at level 3.
        for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i));
        start_xfer(9'd4, 9'd1);
        wait_start(10, n);
        line_busy = 1'b1;
        data_req  = 1'b1;
        tick();
        chk("t4_data0", 32'(data), 32'h0A0);
        chk("t4_level3", 32'(fifo_level), 3);
        wr_data  = 8'hA4;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("t4_level_push_pop", 32'(fifo_level), 3);
        chk("t4_data1", 32'(data), 32'h0A1);
        tick();
        chk("t4_data2", 32'(data), 32'h0A2);
        tick();
        chk("t4_data3", 32'(data), 32'h0A3);
        tick();
        data_req  = 1'b0;
        chk("t4_empty", 32'(data_empty), 1);
        line_busy = 1'b0;
        wait_done(20, n);
        chk("t4_level_left", 32'(fifo_level), 1);

        // Abort after 2 of 4 bytes, colliding with a request.
        for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i));
        start_xfer(9'd4, 9'd1);
        wait_start(10, n);
        line_busy = 1'b1;
        data_req  = 1'b1;
        tick();
        chk("t5_data0", 32'(data), 32'h0A4);
        tick();
        chk("t5_data1", 32'(data), 32'h0C0);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("t5_abort_empty", 32'(data_empty), 1);
        chk("t5_abort_strobe", 32'(data_strobe), 0);
        chk("t5_abort_done", 32'(done), 1);
        chk("t5_abort_busy", 32'(busy), 0);
        chk("t5_abort_level", 32'(fifo_level), 2);
        tick();
        data_req  = 1'b0;
        line_busy = 1'b0;
        chk("t5_idle_req_ignored", 32'(data_strobe), 0);
        chk("t5_idle_level", 32'(fifo_level), 2);
        chk("t5_done_pulse", 32'(done), 0);

        // Illegal count, start while busy, asynchronous reset mid-stream.
        start_xfer(9'd4, 9'd0);
        chk("t6_count0_error", 32'(cfg_error), 1);
        chk("t6_count0_busy", 32'(busy), 0);
        tick();
        chk("t6_error_pulse", 32'(cfg_error), 0);
        start_xfer(9'd2, 9'd1);
        wait_start(10, n);
        start_xfer(9'd4, 9'd0);
        chk("t6_busy_start_no_error", 32'(cfg_error), 0);
        chk("t6_busy_start_busy", 32'(busy), 1);
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        chk("t6_data", 32'(data), 32'h0C1);
        chk("t6_strobe", 32'(data_strobe), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_strobe", 32'(data_strobe), 0);
        chk("t6_rst_data", 32'(data), 0);
        chk("t6_rst_empty", 32'(data_empty), 1);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_level", 32'(fifo_level), 0);
        chk("t6_rst_wr_ready", 32'(wr_ready), 1);
        chk("t6_rst_block_index", 32'(block_index), 0);
        #1;
        reset_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdio_dat_block_source.md
# sdio_dat_block_source

Parametrised multi-block byte source for the SDIO DAT-line transmitter (`sd_response_stream_dat`), replacing the fixed counter-driven test feeder in the slave top level. The block buffers host-side bytes in an internal FIFO and streams them one block at a time. It only starts a block once the whole block is buffered, and sequences start_write / data_req / data_strobe / data_empty for every block of a multi-block transfer. It sits between the application write port and the DAT stream engine.

## Interface
- FIFO_DEPTH, 512, FIFO depth in bytes; power of two, ≥ 2.
- LEN_W, 9, block length field width; `cfg_block_len` = 0 means 2^LEN_W bytes.
- CNT_W, 9, block count field width.

- clock  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_data  in  8  byte to push into the FIFO.
- wr_valid  in  1  push request.
- wr_ready  out  1  FIFO not full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered.
- cfg_start  in  1  one-cycle pulse that starts a transfer.
- cfg_abort  in  1  one-cycle pulse that aborts a transfer.
- cfg_block_len  in  LEN_W  bytes per block, sampled on cfg_start.
- cfg_block_count  in  CNT_W  blocks per transfer, sampled on cfg_start; 0 is illegal.
- start_write  out  1  one-cycle pulse to the DAT engine for each block.
- data_req  in  1  DAT engine requests the next byte.
- data  out  8  byte to the DAT engine.
- data_strobe  out  1  `data` valid, one-cycle pulse.
- data_empty  out  1  no more bytes in the current block.
- line_busy  in  1  DAT engine busy (its read_disabled4).
- busy  out  1  transfer in progress.
- block_index  out  CNT_W  number of blocks completed in the current transfer.
- done  out  1  one-cycle pulse when the last block finishes or an abort completes.
- cfg_error  out  1  one-cycle pulse when a start is rejected.

## Operation
- Reset values: wr_ready=1, fifo_level=0, start_write=0, data=0, data_strobe=0, data_empty=1, busy=0, block_index=0, done=0, cfg_error=0; state=IDLE.
- FIFO: push when wr_valid && wr_ready. Pop happens only inside STREAM. A push and a pop in the same cycle leave fifo_level unchanged. wr_ready=0 exactly when fifo_level==FIFO_DEPTH. Read and write pointers wrap modulo FIFO_DEPTH.
- Effective length: L = (cfg_block_len==0) ? 2^LEN_W : cfg_block_len, held in LEN_W+1 bits.
- IDLE: on cfg_start:
  - cfg_block_count==0 or L>FIFO_DEPTH: cfg_error pulses and the block stays in IDLE.
  - otherwise: latch L and the count, block_index←0, busy←1, go to WAIT_DATA.
- WAIT_DATA: advance to ARM when fifo_level ≥ L and line_busy==0.
- ARM: start_write=1 for one cycle, data_empty←0, bytes_left←L, seen_busy←0, go to STREAM.
- STREAM, on data_req:
  - bytes_left>0: pop one byte; data gets the byte and data_strobe=1 on the next cycle; bytes_left decrements.
  - bytes_left==0: data_empty←1, go to BLOCK_END.
- STREAM also sets seen_busy when line_busy==1.
- BLOCK_END: first wait until seen_busy has been set (line_busy observed high at least once since ARM), then until line_busy==0. Then block_index increments:
  - block_index+1 == count: done pulses, busy←0, go to IDLE.
  - otherwise: go to WAIT_DATA.
- Abort (any non-IDLE state): data_empty←1, data_strobe←0, done pulses, busy←0, go to IDLE. The FIFO is not flushed. Abort takes priority over every same-cycle event except a FIFO push.
- A cfg_start while busy is ignored; no cfg_error.
- A data_req outside STREAM is ignored; data_strobe stays 0.
- data_empty stays 1 from BLOCK_END until the next ARM.

## Timing
- data_req sampled at edge n → data/data_strobe registered at edge n+1. The engine may raise data_req on consecutive cycles, so the sustained rate is 1 byte/cycle.
- Final data_req of a block (bytes_left==0) at n → data_empty=1 at n+1.
- WAIT_DATA→ARM takes 1 cycle after the condition is met; start_write is visible the cycle after ARM is entered.
- done asserts on the cycle after BLOCK_END observes line_busy==0 on the last block.
- reset_n low mid-transfer: all outputs return to reset values immediately (asynchronous); the FIFO empties.

## Test plan
- Push 4 bytes 0x10..0x13, start L=4 count=1, engine requests 5 times → one start_write; data 0x10,0x11,0x12,0x13 each with strobe one cycle after its req; 5th req → data_empty=1; line_busy pulses → done, block_index=1.
- Start L=8 count=3 with only 5 bytes buffered → no start_write until byte 8 arrives. Push 24 bytes total → three start_write pulses, 24 strobes in order, done after the third line_busy fall.
- cfg_block_len=0 with FIFO_DEPTH=512, LEN_W=9, 512 bytes buffered → 512 strobes. The same start with FIFO_DEPTH=256 → cfg_error pulse, busy stays 0.
- Fill the FIFO to FIFO_DEPTH → wr_ready=0. Push and pop in the same cycle at level 3 → level stays 3. Pointer wrap across the block boundary keeps byte order.
- cfg_abort after 2 of 4 bytes → data_empty=1 next cycle, done pulse, remaining 2 bytes still in the FIFO (fifo_level=2), later data_req ignored.
- reset_n low during STREAM → outputs at reset values asynchronously. cfg_start while busy is ignored. cfg_block_count=0 → cfg_error.
